ring_johnson_counter: RTL and testbench
=======================================

Name: ring_johnson_counter

Overview:
- Parametrised shift-register counter. Runtime-selectable mode: ring (one-hot circulate) or Johnson (twisted ring).
- Adds programmable direction, clock enable, parallel load, illegal-state self-correction and a wrap pulse.
- Used as a one-hot sequencer or phase generator. Supersedes the fixed 4-bit ring counter.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2 to 32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset; asserting it (0) resets immediately, independent of clk.
- en  input  1  step enable; 1 = advance one state this cycle.
- mode  input  1  0 = ring, 1 = Johnson.
- dir  input  1  0 = shift toward MSB (left), 1 = shift toward LSB (right).
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value to load.
- dout  output  WIDTH  counter state, registered.
- wrap  output  1  registered one-cycle pulse; counter has just stepped onto the start state.
- fault  output  1  registered one-cycle pulse; an illegal state or load value was corrected.

Behaviour:
- Reset (rst=0, asynchronous): dout = 1 (only bit 0 set), wrap = 0, fault = 0.
  - 1 is the start state and is legal in both modes.
  - Reset held overrides all inputs.
  - Release is synchronous-safe; the first step happens at the first rising edge with rst=1.
- Legality rules for value v:
  - Ring: v is legal iff exactly one bit is set.
  - Johnson: v is legal iff at most one adjacent bit pair (v[i], v[i+1]), i = 0..WIDTH-2, differs. Legal values are all-zeros, all-ones, 0..01..1 and 1..10..0.
- Next-state priority per rising edge, highest first:
  1. Correction: if current dout is illegal for current mode, dout <= 1 and fault <= 1. Applies regardless of en and load.
  2. Load (load=1):
     - load_val legal for current mode: dout <= load_val, fault <= 0.
     - load_val illegal: dout <= 1, fault <= 1.
  3. Step (en=1):
     - Ring, left: dout <= {dout[W-2:0], dout[W-1]}.
     - Ring, right: dout <= {dout[0], dout[W-1:1]}.
     - Johnson, left: dout <= {dout[W-2:0], ~dout[W-1]}.
     - Johnson, right: dout <= {~dout[0], dout[W-1:1]}.
  4. Hold: en=0 and load=0 leave dout unchanged.
- wrap:
  - Set to 1 for one cycle when a step (case 3) produces dout == 1 from a different value. Otherwise 0.
  - Never set by reset, load or correction.
  - Ring left: asserted after leaving state 1<<(W-1).
  - Ring right: asserted after leaving state 2.
  - Johnson left: asserted after leaving all-zeros.
  - Johnson right: asserted after leaving state 3.
- fault: 0 in every cycle that is not case 1 or an illegal load.
- Periods: ring = WIDTH steps; Johnson = 2*WIDTH steps; both directions.
- Mode or dir may change on any cycle.
  - New mode applies to the same edge's legality check and step.
  - Example: switching ring -> Johnson while dout = 0010 (W=4) triggers correction at the next edge: dout = 0001, fault = 1, no step that cycle.
- dir change mid-sequence: the next step simply reverses direction; no extra latency.
- Latency: one clock from en/load/mode to dout; wrap and fault align with the dout update they describe.
- Reset asserted mid-operation: dout = 1, wrap = 0, fault = 0 immediately (asynchronous), including mid-load.

Test Plan:
- Reset and ring-left run (W=4): rst low 50 ns, then mode=0, dir=0, en=1 -> dout 0001, 0010, 0100, 1000, 0001. wrap high only in the cycle dout returns to 0001. fault stays 0.
- Johnson-left run (W=4, mode=1, dir=0, en=1) from reset -> 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001. wrap pulses once per 8 steps.
- Right direction and enable gating, ring mode:
  - en=1 gives 0001 -> 1000 -> 0100.
  - en=0 for 3 cycles holds 0100.
  - Resume gives 0010 -> 0001 with wrap.
- Load: mode=0, load_val=0100 -> dout 0100, fault 0. load_val=0110 -> dout 0001, fault 1 for one cycle. mode=1, load_val=0111 -> dout 0111, fault 0.
- Mode switch correction: ring at 0010, set mode=1 with en=1 -> next edge dout 0001, fault 1, wrap 0. Following edge dout 0011.
- Asynchronous reset mid-run: Johnson at 1110, pull rst low between clock edges -> dout 0001 before the next edge, wrap and fault 0.
  - Repeat the first scenario with WIDTH=8 to confirm an 8-step ring and 16-step Johnson period.

Source files
------------

// File: rtl/ring_johnson_counter.sv
// ring_johnson_counter
//   Parametrised shift-register counter selectable at runtime between ring
//   (one-hot circulate) and Johnson (twisted ring) operation, with direction
//   control, clock enable, parallel load, illegal-state self-correction and a
//   wrap pulse marking arrival at the start state (only bit 0 set).
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-low reset
//   en       in   advance one state this cycle
//   mode     in   0 = ring, 1 = Johnson
//   dir      in   0 = shift toward MSB, 1 = shift toward LSB
//   load     in   synchronous parallel load strobe
//   load_val in   [WIDTH] value to load
//   dout     out  [WIDTH] counter state (registered)
//   wrap     out  one-cycle pulse: a step just landed on the start state
//   fault    out  one-cycle pulse: illegal state or load value was corrected
module ring_johnson_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] dout,
  output logic             wrap,
  output logic             fault
);

  localparam logic [WIDTH-1:0] START = WIDTH'(1);

  // Ring: exactly one bit set. Johnson: at most one adjacent pair differs,
  // i.e. the pairwise-difference vector has at most one bit set.
  function automatic logic is_legal(input logic [WIDTH-1:0] v, input logic m);
    logic [WIDTH-2:0] diff;
    diff = v[WIDTH-1:1] ^ v[WIDTH-2:0];
    if (!m)
      return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
    else
      return (diff & (diff - (WIDTH-1)'(1))) == '0;
  endfunction

  logic [WIDTH-1:0] stepped;
  logic [WIDTH-1:0] dout_nxt;
  logic             wrap_nxt;
  logic             fault_nxt;

  always_comb begin
    stepped = dout;
    unique case ({mode, dir})
      2'b00: stepped = {dout[WIDTH-2:0], dout[WIDTH-1]};
      2'b01: stepped = {dout[0], dout[WIDTH-1:1]};
      2'b10: stepped = {dout[WIDTH-2:0], ~dout[WIDTH-1]};
      2'b11: stepped = {~dout[0], dout[WIDTH-1:1]};
      default: stepped = dout;
    endcase
  end

  // Priority: correction of the current state, then load, then step, then hold.
  always_comb begin
    dout_nxt  = dout;
    wrap_nxt  = 1'b0;
    fault_nxt = 1'b0;
    if (!is_legal(dout, mode)) begin
      dout_nxt  = START;
      fault_nxt = 1'b1;
    end else if (load) begin
      if (is_legal(load_val, mode)) begin
        dout_nxt = load_val;
      end else begin
        dout_nxt  = START;
        fault_nxt = 1'b1;
      end
    end else if (en) begin
      dout_nxt = stepped;
      wrap_nxt = (stepped == START) && (dout != START);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout  <= START;
      wrap  <= 1'b0;
      fault <= 1'b0;
    end else begin
      dout  <= dout_nxt;
      wrap  <= wrap_nxt;
      fault <= fault_nxt;
    end
  end

endmodule

// File: tb/tb_ring_johnson_counter.sv
// tb_ring_johnson_counter
//   Drives a WIDTH=4 and a WIDTH=8 counter with identical stimulus and checks
//   both against a reference model built from the counting rules (bit counts,
//   integer shifts) rather than the design's structure.
module tb_ring_johnson_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, mode, dir, load;
  logic [7:0] load_val;

  logic [3:0] dout4;
  logic [7:0] dout8;
  logic       wrap4, wrap8, fault4, fault8;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference state per instance: index 0 is WIDTH=4, index 1 is WIDTH=8.
  int unsigned wdt   [2] = '{4, 8};
  longint      m_dout[2];
  bit          m_wrap[2];
  bit          m_fault[2];
  longint      e_dout[2];
  bit          e_wrap[2];
  bit          e_fault[2];

  ring_johnson_counter #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
    .load_val(load_val[3:0]), .dout(dout4), .wrap(wrap4), .fault(fault4)
  );

  ring_johnson_counter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
    .load_val(load_val), .dout(dout8), .wrap(wrap8), .fault(fault8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint full_mask(input int unsigned w);
    return (64'd1 << w) - 1;
  endfunction

  function automatic bit legal(input longint v, input int unsigned w, input bit m);
    int unsigned cnt = 0;
    if (!m) begin
      for (int unsigned i = 0; i < w; i++) cnt += int'((v >> i) & 1);
      return cnt == 1;
    end
    for (int unsigned i = 0; i + 1 < w; i++)
      if (((v >> i) & 1) != ((v >> (i + 1)) & 1)) cnt++;
    return cnt <= 1;
  endfunction

  // Left: multiply by two, re-inject the old MSB (ring) or its inverse (Johnson).
  // Right: divide by two, re-inject the old LSB (or its inverse) at the top.
  function automatic longint advance(input longint v, input int unsigned w, input bit m, input bit d);
    longint fed;
    if (!d) begin
      fed = (v >> (w - 1)) & 1;
      if (m) fed = 1 - fed;
      return ((v * 2) & full_mask(w)) + fed;
    end
    fed = v & 1;
    if (m) fed = 1 - fed;
    return (v / 2) + (fed << (w - 1));
  endfunction

  task automatic predict();
    longint lv;
    for (int k = 0; k < 2; k++) begin
      lv = longint'(load_val) & full_mask(wdt[k]);
      e_dout[k] = m_dout[k]; e_wrap[k] = 0; e_fault[k] = 0;
      if (!legal(m_dout[k], wdt[k], mode)) begin
        e_dout[k] = 1; e_fault[k] = 1;
      end else if (load) begin
        if (legal(lv, wdt[k], mode)) e_dout[k] = lv;
        else begin e_dout[k] = 1; e_fault[k] = 1; end
      end else if (en) begin
        e_dout[k] = advance(m_dout[k], wdt[k], mode, dir);
        e_wrap[k] = (e_dout[k] == 1) && (m_dout[k] != 1);
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".dout4"},  32'(dout4),  32'(m_dout[0]));
    check({tag, ".wrap4"},  32'(wrap4),  32'(m_wrap[0]));
    check({tag, ".fault4"}, 32'(fault4), 32'(m_fault[0]));
    check({tag, ".dout8"},  32'(dout8),  32'(m_dout[1]));
    check({tag, ".wrap8"},  32'(wrap8),  32'(m_wrap[1]));
    check({tag, ".fault8"}, 32'(fault8), 32'(m_fault[1]));
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_dout[k] = 1; m_wrap[k] = 0; m_fault[k] = 0;
    end
  endtask

  // One clock: predict from inputs present at the edge, sample 1 ns later.
  task automatic tick(input string tag);
    predict();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_dout[k] = e_dout[k]; m_wrap[k] = e_wrap[k]; m_fault[k] = e_fault[k];
    end
    compare_all(tag);
  endtask

  // Reset asserted between edges; outputs must clear before any clock edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 model_reset();
    compare_all(tag);
    #1 rst = 1'b1;
  endtask

  function automatic logic [7:0] pick_load_val();
    logic [7:0] r = 8'($urandom);
    int unsigned k = $urandom_range(0, 7);
    case ($urandom_range(0, 3))
      0: return r;
      1: return 8'(1) << k;
      2: return (8'(1) << k) - 8'(1);
      default: return ~((8'(1) << k) - 8'(1));
    endcase
  endfunction

  logic [3:0] ring_l [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] john_l [8] = '{4'b0011, 4'b0111, 4'b1111, 4'b1110,
                             4'b1100, 4'b1000, 4'b0000, 4'b0001};

  initial begin
    rst = 1'b0; en = 0; mode = 0; dir = 0; load = 0; load_val = '0;
    model_reset();
    #50;
    compare_all("reset");
    @(negedge clk) rst = 1'b1;

    // Ring left from reset, W=4 sequence fixed by hand.
    en = 1; mode = 0; dir = 0;
    for (int i = 0; i < 4; i++) begin
      tick("ring_left");
      check("ring_left.seq", 32'(dout4), 32'(ring_l[i]));
      check("ring_left.wrap", 32'(wrap4), 32'(i == 3));
    end
    for (int i = 0; i < 4; i++) tick("ring_left8");

    // Johnson left from reset.
    async_reset("rst_j");
    mode = 1;
    for (int i = 0; i < 8; i++) begin
      tick("john_left");
      check("john_left.seq", 32'(dout4), 32'(john_l[i]));
    end
    for (int i = 0; i < 8; i++) tick("john_left8");

    // Async reset while Johnson sits at 1110 (W=4).
    async_reset("rst_j2");
    for (int i = 0; i < 4; i++) tick("john_to_e");
    check("john_at_e", 32'(dout4), 32'hE);
    async_reset("rst_mid");

    // Ring right with enable gating.
    mode = 0; dir = 1; en = 1;
    tick("ring_right"); tick("ring_right");
    check("ring_right.seq", 32'(dout4), 32'h4);
    en = 0;
    for (int i = 0; i < 3; i++) tick("hold");
    check("hold.seq", 32'(dout4), 32'h4);
    en = 1;
    tick("resume"); tick("resume");
    check("resume.wrap", 32'(wrap4), 32'h1);

    // Loads.
    en = 0; load = 1; mode = 0; load_val = 8'h04; tick("load_ok");
    load_val = 8'h06; tick("load_bad");
    check("load_bad.fault", 32'(fault4), 32'h1);
    mode = 1; load_val = 8'h07; tick("load_john");
    load = 0;

    // Mode switch correction: ring at 0010 then Johnson.
    async_reset("rst_ms");
    mode = 0; dir = 0; en = 1; tick("ms_pre");
    mode = 1; tick("ms_fix");
    check("ms_fix.fault", 32'(fault4), 32'h1);
    tick("ms_next");
    check("ms_next.seq", 32'(dout4), 32'h3);

    // Randomised run.
    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      load     = ($urandom_range(0, 15) == 0);
      load_val = pick_load_val();
      if ($urandom_range(0, 31) == 0) mode = ~mode;
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      tick("rand");
      if ($urandom_range(0, 199) == 0) async_reset("rand_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
